mips32_mem_dump: RTL and testbench

//   Read-back engine for the MIPS32 unified memory: reads a block of 32-bit words
//   and streams them out as bytes over a valid/ready interface.

---
 rtl/mips32_mem_dump.sv | 138 +++++++++++++
 tb/tb_mips32_mem_dump.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_mem_dump.sv
// Memory read-back engine: walks a block of 32-bit words through a synchronous
// read port and streams each word out as four bytes, MSB first, on a
// valid/ready byte interface.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start
// READ  | read strobe and address presented to the memory
// WAIT  | memory data returns and is captured into the shift register
// SEND  | four bytes offered to the sink, one per handshake
// FIN   | one-cycle done pulse, then back to IDLE
module mips32_mem_dump #(
    parameter int ADDR_W = 10
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_FIN
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_shift;
    logic [1:0]        r_byte;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_en;
    logic              r_tx_valid;

    logic              w_hs;
    logic [ADDR_W-1:0] w_next_addr;

    assign w_hs        = r_tx_valid & tx_ready;
    // Address arithmetic wraps naturally at 2**ADDR_W.
    assign w_next_addr = r_addr + ADDR_W'(1);

    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_rd_en = r_rd_en;
    assign mem_addr  = r_mem_addr;
    // The outgoing byte is always the top of the shift register, so it is
    // inherently held while the sink stalls.
    assign tx_data   = r_shift[31:24];
    assign tx_valid  = r_tx_valid;

    // Sequencer with all outputs registered; each output is set on entry to the
    // state that owns it and cleared on exit.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_count    <= '0;
            r_mem_addr <= '0;
            r_shift    <= '0;
            r_byte     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_en    <= 1'b0;
            r_tx_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            r_addr     <= base_addr;
                            r_count    <= word_count;
                            r_mem_addr <= base_addr;
                            r_rd_en    <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= S_READ;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end
                    end
                end
                S_READ: begin
                    r_rd_en <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_shift    <= mem_rdata;
                    r_byte     <= 2'd0;
                    r_tx_valid <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (w_hs) begin
                        r_shift <= {r_shift[23:0], 8'h00};
                        r_byte  <= r_byte + 2'd1;
                        if (r_byte == 2'd3) begin
                            r_tx_valid <= 1'b0;
                            if (r_count != ADDR_W'(1)) begin
                                r_addr     <= w_next_addr;
                                r_count    <= r_count - ADDR_W'(1);
                                r_mem_addr <= w_next_addr;
                                r_rd_en    <= 1'b1;
                                r_state    <= S_READ;
                            end else begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_FIN;
                            end
                        end
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_mem_dump.sv
// Scoreboard bench for mips32_mem_dump: expected addresses and bytes are queued
// when a dump is issued; a negedge monitor pops and compares as the DUT
// presents read strobes and byte handshakes.
module tb_mips32_mem_dump;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk1;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] word_count;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;

    mips32_mem_dump #(.ADDR_W(AW)) dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Behavioural memory with a synchronous read port.
    logic [31:0] mem [DEPTH];
    always @(posedge clk1) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int ready_mode = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int hs_cnt = 0;
    int done_cyc = -1;
    int first_tx_cyc = -1;
    int start_cyc = 0;

    logic [7:0]    exp_bytes[$];
    logic [AW-1:0] exp_addr[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string name, input logic [31:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: unexpected event, value %0h, expected none (t=%0t)", name, act, $time);
    endtask

    initial forever begin
        @(posedge clk1);
        cyc++;
    end

    // Sink readiness: always ready, or a random ~55% accept rate.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk1);
            #1;
            tx_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 55);
        end
    end

    // Monitor: compares read addresses, bytes, hold-while-stalled, done pulses.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic [7:0] eb;
        logic [AW-1:0] ea;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk1);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("tx_valid_held", 32'(tx_valid), 32'd1);
                    check("tx_data_held", 32'(tx_data), 32'(prev_data));
                end
                if (mem_rd_en) begin
                    if (exp_addr.size() == 0) fail_event("rd_en_extra", 32'(mem_addr));
                    else begin
                        ea = exp_addr.pop_front();
                        check("mem_addr", 32'(mem_addr), 32'(ea));
                    end
                    check("busy_during_read", 32'(busy), 32'd1);
                end
                if (tx_valid && first_tx_cyc < 0) first_tx_cyc = cyc;
                if (tx_valid && tx_ready) begin
                    hs_cnt++;
                    if (exp_bytes.size() == 0) fail_event("tx_byte_extra", 32'(tx_data));
                    else begin
                        eb = exp_bytes.pop_front();
                        check("tx_byte", 32'(tx_data), 32'(eb));
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("busy_low_at_done", 32'(busy), 32'd0);
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
            end
        end
    end

    // Reference: word i of the dump lives at (base+i) mod depth, bytes MSB first.
    task automatic expect_dump(input int base, input int count);
        int a;
        logic [31:0] w;
        for (int i = 0; i < count; i++) begin
            a = (base + i) % DEPTH;
            w = mem[a];
            exp_addr.push_back(AW'(a));
            for (int b = 3; b >= 0; b--) exp_bytes.push_back(w[b*8 +: 8]);
        end
    endtask

    task automatic issue_start(input int base, input int count);
        @(posedge clk1);
        #1;
        base_addr  = AW'(base);
        word_count = AW'(count);
        start      = 1'b1;
        start_cyc  = cyc;
        first_tx_cyc = -1;
        @(posedge clk1);
        #1;
        start = 1'b0;
    endtask

    task automatic run_dump(input int base, input int count, input bit timed, input bit repulse);
        int budget;
        expect_dump(base, count);
        exp_done++;
        issue_start(base, count);
        budget = 50 + count * 120;
        for (int k = 0; k < budget && done_cnt != exp_done; k++) begin
            @(posedge clk1);
            #1;
            if (repulse && k == 3) begin
                base_addr  = AW'(base + 17);
                word_count = AW'(5);
                start      = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(done_cnt), 32'(exp_done));
        @(posedge clk1);
        #1;
        check("bytes_left", 32'(exp_bytes.size()), 32'd0);
        check("addrs_left", 32'(exp_addr.size()), 32'd0);
        check("busy_after_dump", 32'(busy), 32'd0);
        if (timed) begin
            // FIN follows the last SEND cycle directly: 6 cycles per word plus one.
            check("done_latency", 32'(done_cyc - start_cyc), 32'(6 * count + 1));
            if (count > 0) check("first_tx_latency", 32'(first_tx_cyc - start_cyc), 32'd3);
        end
        exp_bytes.delete();
        exp_addr.delete();
    endtask

    initial begin
        int hs0;
        int done0;
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[200] = 32'h0000_0007;
        mem[0]   = 32'h280a_00c8;
        mem[1]   = 32'h2802_0001;
        mem[2]   = 32'h0c94_a000;

        #23;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        @(posedge clk1);
        #1;
        rst_n = 1'b1;

        ready_mode = 0;
        run_dump(200, 1, 1'b1, 1'b0);
        run_dump(0, 3, 1'b1, 1'b0);
        ready_mode = 1;
        run_dump(0, 3, 1'b0, 1'b0);
        ready_mode = 0;
        run_dump(1023, 2, 1'b1, 1'b0);
        run_dump(0, 0, 1'b1, 1'b0);
        run_dump(40, 2, 1'b1, 1'b1);

        // Reset during SEND of the third byte of the first word.
        expect_dump(0, 3);
        hs0   = hs_cnt;
        done0 = done_cnt;
        issue_start(0, 3);
        for (int k = 0; k < 60 && hs_cnt < hs0 + 2; k++) @(posedge clk1);
        check("pre_reset_handshakes", 32'(hs_cnt - hs0), 32'd2);
        #3;
        check("pre_reset_valid", 32'(tx_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        exp_bytes.delete();
        exp_addr.delete();
        repeat (3) @(posedge clk1);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk1);
        check("no_done_after_reset", 32'(done_cnt), 32'(done0));
        run_dump(0, 3, 1'b1, 1'b0);

        for (int t = 0; t < 8; t++) begin
            ready_mode = int'($urandom_range(0, 1));
            run_dump(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 5)),
                     ready_mode == 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
